lsu_mem_port: RTL and testbench

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

---
 rtl/lsu_mem_port.sv | 132 +++++++++++++
 tb/tb_lsu_mem_port.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// Load/store unit port onto a single-ported word memory with a shared tri-state data bus.
// Optional LSU_MISALIGN_ERR_EN rejects misaligned or illegal-size requests with rsp_err.
module lsu_mem_port #(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  tri   [31:0]           mem_data,
  output logic                  mem_re,
  output logic                  mem_we
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e                state_q;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wword_q;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic                  req_misalign;

`ifdef LSU_MISALIGN_ERR_EN
  assign req_misalign = (req_size == 2'b11) ||
                        ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign req_misalign = 1'b0;
`endif

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic uns, input logic [1:0] off);
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    sh_b = word >> {off, 3'b000};
    sh_h = word >> {off[1], 4'b0000};
    case (size)
      2'b00:   return uns ? {24'b0, sh_b[7:0]} : {{24{sh_b[7]}}, sh_b[7:0]};
      2'b01:   return uns ? {16'b0, sh_h[15:0]} : {{16{sh_h[15]}}, sh_h[15:0]};
      default: return word;
    endcase
  endfunction

  // Replace only the addressed lane(s) of the word read back from memory.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] res;
    res = word;
    case (size)
      2'b00:   res[{off, 3'b000} +: 8] = wdata[7:0];
      2'b01:   res[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: res = wdata;
    endcase
    return res;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wword_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q       <= req_we;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            addr_q     <= req_addr;
            wword_q    <= req_wdata;
            rdata_q    <= '0;
            err_q      <= req_misalign;
            if (req_misalign) begin
              state_q <= StResp;
            end else if (req_we && req_size[1]) begin
              state_q <= StWr;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StRd: begin
          if (we_q) begin
            wword_q <= store_merge(mem_data, wword_q, size_q, addr_q[1:0]);
            state_q <= StWr;
          end else begin
            rdata_q <= load_extend(mem_data, size_q, unsigned_q, addr_q[1:0]);
            state_q <= StResp;
          end
        end
        StWr: state_q <= StResp;
        StResp: begin
          if (rsp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_re    = (state_q == StRd);
  assign mem_we    = (state_q == StWr);
  assign mem_addr  = (mem_re || mem_we) ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_data  = mem_we ? wword_q : 32'bz;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed self-checking bench for lsu_mem_port against a 16-word behavioural memory.
module tb_lsu_mem_port;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] mem_addr;
  tri   [31:0] mem_data;
  logic        mem_re;
  logic        mem_we;

  logic [31:0] mem [16];
  logic        poke_en = 1'b0;
  logic [3:0]  poke_idx = 4'd0;
  logic [31:0] poke_val = 32'd0;

  int n_vec = 0;
  int n_err = 0;

  lsu_mem_port #(.ADDR_WIDTH(16)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_re       (mem_re),
    .mem_we       (mem_we)
  );

  always #5 clock = ~clock;

  assign mem_data = mem_re ? mem[mem_addr[5:2]] : 32'bz;

  always @(posedge clock) begin
    if (mem_we) mem[mem_addr[5:2]] <= mem_data;
    else if (poke_en) mem[poke_idx] <= poke_val;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clock);
    poke_en  = 1'b1;
    poke_idx = idx;
    poke_val = val;
    @(posedge clock);
    #1 poke_en = 1'b0;
  endtask

  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [15:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int nrd, output int nwr, output logic [31:0] wseen,
                         output logic [15:0] aseen);
    lat = 0; rdata = '0; err = 1'b0; nrd = 0; nwr = 0; wseen = '0; aseen = '0;
    @(negedge clock);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (mem_re) nrd++;
      if (mem_we) begin
        nwr++;
        wseen = mem_data;
      end
      if (mem_re || mem_we) aseen = mem_addr;
      if (rsp_valid) begin
        lat = k; rdata = rsp_rdata; err = rsp_err;
        break;
      end
    end
    @(posedge clock);
    #1;
  endtask

  int          lat, nrd, nwr;
  logic [31:0] rdata, wseen;
  logic [15:0] aseen;
  logic        err;

  initial begin
    reset_n = 1'b0; rsp_ready = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_size = 2'b00; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    #2;
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_mem_re_we", {30'b0, mem_re, mem_we}, 32'd0);
    check("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    #1 check("rst_req_ready", {31'b0, req_ready}, 32'd1);

    poke(4'd0, 32'h8234_5678);
    run_req(1'b0, 2'b00, 1'b0, 16'h0003, '0, lat, rdata, err, nrd, nwr, wseen, aseen);
    check("lb_lat", lat, 32'd2);
    check("lb_rdata", rdata, 32'hFFFF_FF82);
    check("lb_rd_cycles", nrd, 32'd1);
    run_req(1'b0, 2'b00, 1'b1, 16'h0003, '0, lat, rdata, err, nrd, nwr, wseen, aseen);
    check("lbu_rdata", rdata, 32'h0000_0082);
    run_req(1'b0, 2'b01, 1'b0, 16'h0002, '0, lat, rdata, err, nrd, nwr, wseen, aseen);
    check("lh_rdata", rdata, 32'hFFFF_8234);
    run_req(1'b0, 2'b01, 1'b1, 16'h0000, '0, lat, rdata, err, nrd, nwr, wseen, aseen);
    check("lhu_rdata", rdata, 32'h0000_5678);

    poke(4'd0, 32'h1122_3344);
    run_req(1'b1, 2'b00, 1'b0, 16'h0001, 32'h0000_00AB, lat, rdata, err, nrd, nwr, wseen,
            aseen);
    check("sb_lat", lat, 32'd3);
    check("sb_rd_wr_cycles", {nrd[15:0], nwr[15:0]}, {16'd1, 16'd1});
    check("sb_mem_data", wseen, 32'h1122_AB44);
    check("sb_rsp_rdata", rdata, 32'd0);
    run_req(1'b0, 2'b10, 1'b0, 16'h0000, '0, lat, rdata, err, nrd, nwr, wseen, aseen);
    check("lw_after_sb", rdata, 32'h1122_AB44);

    run_req(1'b1, 2'b10, 1'b0, 16'h0008, 32'hDEAD_BEEF, lat, rdata, err, nrd, nwr, wseen,
            aseen);
    check("sw_lat", lat, 32'd2);
    check("sw_rd_wr_cycles", {nrd[15:0], nwr[15:0]}, {16'd0, 16'd1});
    check("sw_mem_addr", {16'b0, aseen}, 32'h0000_0008);
    check("sw_mem_word", mem[2], 32'hDEAD_BEEF);

    poke(4'd1, 32'h1122_3344);
    run_req(1'b1, 2'b01, 1'b0, 16'h0006, 32'h5555_CAFE, lat, rdata, err, nrd, nwr, wseen,
            aseen);
    check("sh_mem_data", wseen, 32'hCAFE_3344);
    check("sh_mem_addr", {16'b0, aseen}, 32'h0000_0004);

    // Response back-pressure: everything must hold while rsp_ready is low.
    rsp_ready = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 16'h0008;
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    check("stall_lat", lat, 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("stall_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check("stall_req_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    check("stall_release_valid", {31'b0, rsp_valid}, 32'd0);
    check("stall_release_ready", {31'b0, req_ready}, 32'd1);

    run_req(1'b0, 2'b01, 1'b0, 16'h0003, '0, lat, rdata, err, nrd, nwr, wseen, aseen);
`ifdef LSU_MISALIGN_ERR_EN
    check("lh3_err", {31'b0, err}, 32'd1);
    check("lh3_rdata", rdata, 32'd0);
    check("lh3_no_re", nrd, 32'd0);
    check("lh3_lat", lat, 32'd1);
`else
    check("lh3_err", {31'b0, err}, 32'd0);
    check("lh3_rdata", rdata, 32'h0000_1122);
    check("lh3_lat", lat, 32'd2);
`endif

    // Reset landing in the middle of a sub-word store's write cycle.
    poke(4'd3, 32'h5566_7788);
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_addr = 16'h000C;
    req_wdata = 32'h0000_1234;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    #1 check("abort_in_wr", {31'b0, mem_we}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("abort_mem_we", {31'b0, mem_we}, 32'd0);
    check("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    #1;
    check("abort_mem_word", mem[3], 32'h5566_7788);
    check("abort_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (3) @(negedge clock);
    check("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
